// File: rtl/hls_deadlock_detect_unit_confirm_pkg.sv
// Shared definitions for the confirming deadlock detection unit:
// FSM state encoding, width helper and one-hot self-bit helper.
package hls_deadlock_detect_unit_confirm_pkg;

  // FSM state encoding (2 bits)
  typedef logic [1:0] dl_state_t;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CONFIRM  = 2'd1;
  localparam logic [1:0] ST_DETECTED = 2'd2;

  // Ceiling log2 for constant width derivation; returns at least 1.
  function automatic int dl_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // One-hot vector with bit idx set; callers slice to PROC_NUM bits.
  function automatic logic [31:0] dl_onehot(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/hls_dl_confirm_counter.sv
// Saturating consecutive-cycle counter. Counts cycles with cand high,
// drops to zero on the first cand-low cycle, and flags when the current
// cycle is the one that brings the run up to the threshold.
module hls_dl_confirm_counter
  import hls_deadlock_detect_unit_confirm_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cand,
  input  logic             clear,
  input  logic [CNT_W-1:0] threshold,
  output logic             reached
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // Next count value and threshold hit for the cycle being sampled
  always_comb begin
    cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    reached = cand & (cnt_inc >= {1'b0, threshold});
  end

  // Run-length register: clear wins, saturates at the threshold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cand) begin
      if (cnt_inc <= {1'b0, threshold}) cnt <= cnt_inc[CNT_W-1:0];
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/hls_deadlock_detect_unit_confirm.sv
// Per-process deadlock detection unit with a confirmation filter.
// Propagates the dependence vector around the ring, reports a deadlock
// only after the self-dependence holds for CONFIRM_CYCLES consecutive
// cycles, snapshots the blocking state at that moment, and can originate
// the report token itself one cycle after detection.
// Token handshake: a token is a single-cycle level on token_in_vec; it is
// forwarded on the next edge onto every output channel this process is
// blocked on, unless token_clear withdraws it in the same cycle.
module hls_deadlock_detect_unit_confirm
  import hls_deadlock_detect_unit_confirm_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4,
  parameter int AUTO_ORIGIN    = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [PROC_NUM-1:0]             dl_dep_snap,
  output logic [IN_CHAN_NUM-1:0]          dl_chan_snap,
  output logic                            dl_snap_vld,
  output logic [1:0]                      dbg_state
);

  localparam int CNT_W = dl_clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(CONFIRM_CYCLES);
  localparam logic [31:0] ONEHOT_FULL = dl_onehot(PROC_ID);
  localparam logic [PROC_NUM-1:0] SELF_BIT = ONEHOT_FULL[PROC_NUM-1:0];

  if (CONFIRM_CYCLES < 1) begin : g_bad_confirm
    $error("CONFIRM_CYCLES must be at least 1");
  end
  if (PROC_ID < 0 || PROC_ID >= PROC_NUM) begin : g_bad_proc_id
    $error("PROC_ID out of range");
  end

  dl_state_t           state, state_nxt;
  logic [PROC_NUM-1:0] dep_comb, dep, dep_reg;
  logic                gate, cand, reached, enter_det, auto_pulse;
  logic                st_detected;

  // Merge the valid incoming dependence vectors
  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      dep_comb |= {PROC_NUM{in_chan_dep_vld_vec[i]}} &
                  in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  // Freeze the dependence once a deadlock is flagged, unless a token arrives
  always_comb begin
    gate = ~dl_detect_in | (|token_in_vec);
    dep  = gate ? dep_comb : dep_reg;
    cand = gate & dep[PROC_ID] & (|proc_dep_vld_vec);
  end

  assign st_detected          = (state == ST_DETECTED);
  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF_BIT;
  assign dbg_state            = state;

  // In DETECTED the counter is held saturated; it only restarts on clear
  hls_dl_confirm_counter #(.CNT_W(CNT_W)) u_confirm_counter (
    .clock     (clock),
    .reset     (reset),
    .cand      (cand | st_detected),
    .clear     (st_detected & token_clear),
    .threshold (THRESH),
    .reached   (reached)
  );

  // Confirmation FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cand) state_nxt = reached ? ST_DETECTED : ST_CONFIRM;
      ST_CONFIRM: begin
        if (!cand)        state_nxt = ST_IDLE;
        else if (reached) state_nxt = ST_DETECTED;
      end
      ST_DETECTED: if (token_clear) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    enter_det = (state != ST_DETECTED) && (state_nxt == ST_DETECTED);
  end

  // State, dependence, report flag, snapshot and token registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      dep_reg       <= '0;
      dl_detect_out <= 1'b0;
      dl_snap_vld   <= 1'b0;
      dl_dep_snap   <= '0;
      dl_chan_snap  <= '0;
      auto_pulse    <= 1'b0;
      token_out_vec <= '0;
    end else begin
      state         <= state_nxt;
      dep_reg       <= (|proc_dep_vld_vec) ? dep : '0;
      dl_detect_out <= (state_nxt == ST_DETECTED);
      dl_snap_vld   <= (state_nxt == ST_DETECTED);
      if (enter_det) begin
        dl_dep_snap  <= dep;
        dl_chan_snap <= in_chan_dep_vld_vec;
      end
      auto_pulse    <= (AUTO_ORIGIN != 0) && enter_det;
      if (((|token_in_vec) & ~token_clear) | origin | auto_pulse)
        token_out_vec <= proc_dep_vld_vec;
      else
        token_out_vec <= '0;
    end
  end

endmodule

// File: tb/tb_hls_deadlock_detect_unit_confirm.sv
// Bench for the confirming deadlock detection unit (PROC_ID=1,
// CONFIRM_CYCLES=4, AUTO_ORIGIN=1). A cycle model predicts every output
// after each edge; predictions are queued and compared after the edge.
module tb_hls_deadlock_detect_unit_confirm;

  localparam int EW = 17;

  logic       clock;
  logic       reset;
  logic [2:0] proc_dep_vld_vec;
  logic [1:0] in_chan_dep_vld_vec;
  logic [7:0] in_chan_dep_data_vec;
  logic [1:0] token_in_vec;
  logic       dl_detect_in;
  logic       origin;
  logic       token_clear;
  logic [2:0] out_chan_dep_vld_vec;
  logic [3:0] out_chan_dep_data;
  logic [2:0] token_out_vec;
  logic       dl_detect_out;
  logic [3:0] dl_dep_snap;
  logic [1:0] dl_chan_snap;
  logic       dl_snap_vld;
  logic [1:0] dbg_state;

  hls_deadlock_detect_unit_confirm #(
    .PROC_NUM(4), .PROC_ID(1), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3),
    .CONFIRM_CYCLES(4), .AUTO_ORIGIN(1)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .proc_dep_vld_vec     (proc_dep_vld_vec),
    .in_chan_dep_vld_vec  (in_chan_dep_vld_vec),
    .in_chan_dep_data_vec (in_chan_dep_data_vec),
    .token_in_vec         (token_in_vec),
    .dl_detect_in         (dl_detect_in),
    .origin               (origin),
    .token_clear          (token_clear),
    .out_chan_dep_vld_vec (out_chan_dep_vld_vec),
    .out_chan_dep_data    (out_chan_dep_data),
    .token_out_vec        (token_out_vec),
    .dl_detect_out        (dl_detect_out),
    .dl_dep_snap          (dl_dep_snap),
    .dl_chan_snap         (dl_chan_snap),
    .dl_snap_vld          (dl_snap_vld),
    .dbg_state            (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [3:0] m_dep_reg, m_dsnap;
  logic [1:0] m_csnap;
  logic [2:0] m_tok;
  logic       m_det, m_auto;
  int         m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_vec();
    logic [1:0] st;
    st = m_det ? 2'd2 : ((m_run > 0) ? 2'd1 : 2'd0);
    return {m_dep_reg | 4'b0010, m_tok, m_det, m_dsnap, m_csnap, m_det, st};
  endfunction

  task automatic model_reset();
    m_dep_reg = '0; m_dsnap = '0; m_csnap = '0; m_tok = '0;
    m_det = 1'b0; m_auto = 1'b0; m_run = 0;
  endtask

  task automatic compare_outputs(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_dep_data"},  32'(out_chan_dep_data), 32'(e[16:13]));
    check({tag, "_token_out"}, 32'(token_out_vec),     32'(e[12:10]));
    check({tag, "_detect"},    32'(dl_detect_out),     32'(e[9]));
    check({tag, "_dep_snap"},  32'(dl_dep_snap),       32'(e[8:5]));
    check({tag, "_chan_snap"}, 32'(dl_chan_snap),      32'(e[4:3]));
    check({tag, "_snap_vld"},  32'(dl_snap_vld),       32'(e[2]));
    check({tag, "_state"},     32'(dbg_state),         32'(e[1:0]));
    check({tag, "_vld_pass"},  32'(out_chan_dep_vld_vec), 32'(proc_dep_vld_vec));
  endtask

  // Predict the effect of one edge with the current inputs, then compare.
  task automatic step(input string tag);
    logic [3:0] dc, d;
    logic       g, c, auto_n;
    logic [2:0] tok_n;
    dc = (in_chan_dep_vld_vec[0] ? in_chan_dep_data_vec[3:0] : 4'b0) |
         (in_chan_dep_vld_vec[1] ? in_chan_dep_data_vec[7:4] : 4'b0);
    g = !dl_detect_in || (|token_in_vec);
    d = g ? dc : m_dep_reg;
    c = g && d[1] && (|proc_dep_vld_vec);
    tok_n = (((|token_in_vec) && !token_clear) || origin || m_auto) ? proc_dep_vld_vec : 3'b000;
    auto_n = 1'b0;
    if (m_det) begin
      if (token_clear) begin m_det = 1'b0; m_run = 0; end
    end else if (c) begin
      m_run++;
      if (m_run >= 4) begin
        m_det = 1'b1; m_dsnap = d; m_csnap = in_chan_dep_vld_vec; auto_n = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    m_dep_reg = (|proc_dep_vld_vec) ? d : 4'b0;
    m_tok  = tok_n;
    m_auto = auto_n;
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
    compare_outputs(tag);
  endtask

  task automatic drive(input logic [2:0] pdv, input logic [1:0] vld, input logic [7:0] data,
                       input logic dli, input logic [1:0] tin, input logic org, input logic clr);
    proc_dep_vld_vec = pdv; in_chan_dep_vld_vec = vld; in_chan_dep_data_vec = data;
    dl_detect_in = dli; token_in_vec = tin; origin = org; token_clear = clr;
  endtask

  task automatic reset_check(input string tag);
    model_reset();
    exp_q.push_back(model_vec());
    compare_outputs(tag);
  endtask

  initial begin
    reset = 1'b0;
    drive(3'b000, 2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    model_reset();
    #12;
    reset_check("rst_init");
    reset = 1'b1;
    #4;

    // persistent self-dependence: detect after the 4th edge, then auto token
    drive(3'b001, 2'b01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("persist");

    // clear collides with cand: back to IDLE, snapshot retained, re-detect
    token_clear = 1'b1; step("clr_cand");
    token_clear = 1'b0;
    for (int i = 0; i < 5; i++) step("redetect");
    token_clear = 1'b1; step("clr2");
    token_clear = 1'b0;

    // glitch filter: 3 cand edges, one gap, then 4 more needed
    for (int i = 0; i < 3; i++) step("glitch_pre");
    in_chan_dep_data_vec = 8'h00; step("glitch_gap");
    in_chan_dep_data_vec = 8'h02;
    for (int i = 0; i < 5; i++) step("glitch_post");
    token_clear = 1'b1; step("clr3");
    token_clear = 1'b0;

    // frozen dependence: global flag set, no token, new inputs ignored
    drive(3'b001, 2'b01, 8'h08, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("frozen");

    // token forwarding rules
    drive(3'b101, 2'b00, 8'h00, 1'b0, 2'b10, 1'b0, 1'b1); step("tok_clr");
    token_clear = 1'b0; step("tok_fwd");
    token_in_vec = 2'b00; origin = 1'b1; step("tok_origin");
    origin = 1'b0; step("tok_idle");

    // auto origin with pdv=101
    drive(3'b101, 2'b01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("auto101");
    token_clear = 1'b1; step("clr4");

    // randomized traffic biased toward self-dependence
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        drive(3'b001, 2'b01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
      else
        drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
              1'b0);
      token_clear = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    // async reset in the middle of CONFIRM (count = 2)
    drive(3'b000, 2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); step("pre_idle");
    drive(3'b001, 2'b01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
    step("confirm1");
    step("confirm2");
    reset = 1'b0;
    #1;
    reset_check("rst_mid");
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step("post_rst");

    if (exp_q.size() != 0) check("q_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_detect_unit_confirm.md
Name: hls_deadlock_detect_unit_confirm

Overview:
- Next-generation per-process deadlock detection unit for HLS dataflow regions. Sits beside each process, on the dependence and token ring shared with its peers.
- Propagates the process-dependence vector and runs token-controlled report arbitration, as the current unit does.
- New: a deadlock is reported only after the self-dependence condition holds for a programmable number of consecutive cycles.
- New: a snapshot of the blocking dependence and channel state is latched, and the unit can optionally originate the report token itself.

Parameters:
PROC_NUM, 4, number of processes in the dataflow region (width of dependence vectors)
PROC_ID, 0, this process's bit index, 0..PROC_NUM-1
IN_CHAN_NUM, 2, number of incoming dependence channels, >=1
OUT_CHAN_NUM, 3, number of outgoing dependence channels, >=1
CONFIRM_CYCLES, 4, consecutive candidate cycles required before reporting; >=1, 0 is an elaboration error
AUTO_ORIGIN, 0, 1 = unit originates the token one cycle after entering DETECTED
CNT_W, clog2(CONFIRM_CYCLES+1), confirm counter width (derived localparam)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
proc_dep_vld_vec  in  OUT_CHAN_NUM  process blocked on each output channel
in_chan_dep_vld_vec  in  IN_CHAN_NUM  incoming dependence valid per channel
in_chan_dep_data_vec  in  IN_CHAN_NUM*PROC_NUM  incoming dependence vectors, channel i at [i*PROC_NUM +: PROC_NUM]
token_in_vec  in  IN_CHAN_NUM  report token per incoming channel
dl_detect_in  in  1  global deadlock already flagged
origin  in  1  external token origin request
token_clear  in  1  withdraw token / acknowledge report
out_chan_dep_vld_vec  out  OUT_CHAN_NUM  equals proc_dep_vld_vec (combinational)
out_chan_dep_data  out  PROC_NUM  dep_reg OR onehot(PROC_ID)
token_out_vec  out  OUT_CHAN_NUM  registered outgoing token
dl_detect_out  out  1  registered confirmed-deadlock flag
dl_dep_snap  out  PROC_NUM  dependence vector latched at confirmation
dl_chan_snap  out  IN_CHAN_NUM  in_chan_dep_vld_vec latched at confirmation
dl_snap_vld  out  1  snapshot valid

Behaviour:
- Reset values:
  - dep_reg, token_out_vec, dl_detect_out, dl_dep_snap, dl_chan_snap and dl_snap_vld are all 0; counter 0; state IDLE.
  - out_chan_dep_data therefore reads onehot(PROC_ID) during reset.
  - Reset asserted mid-operation clears all of the above immediately, with no clock edge needed.
- dep_comb = OR over i of (in_chan_dep_vld_vec[i] replicated across PROC_NUM bits) AND channel i data.
- gate = ~dl_detect_in | (|token_in_vec).
- dep = gate ? dep_comb : dep_reg.
- Each edge: dep_reg <= (|proc_dep_vld_vec) ? dep : 0.
- cand = gate & dep[PROC_ID] & (|proc_dep_vld_vec). cand is combinational and internal only.
- FSM states: IDLE, CONFIRM, DETECTED.
  - IDLE: if cand, set cnt to 1. If CONFIRM_CYCLES==1, go to DETECTED; otherwise go to CONFIRM.
  - CONFIRM: if ~cand, set cnt to 0 and go to IDLE. Otherwise increment cnt; when cnt+1 == CONFIRM_CYCLES, go to DETECTED.
  - DETECTED: stays until token_clear; then go to IDLE with cnt=0. Ignores cand.
- Entry into DETECTED (same edge): dl_detect_out <= 1, dl_snap_vld <= 1, dl_dep_snap <= dep, dl_chan_snap <= in_chan_dep_vld_vec.
- Report latency: dl_detect_out rises at the edge sampling the CONFIRM_CYCLES-th consecutive cand=1.
- Leaving DETECTED: dl_detect_out <= 0 and dl_snap_vld <= 0. Snapshot data holds its value until the next confirmation overwrites it.
- token_clear while in IDLE or CONFIRM has no FSM effect.
- token_clear and cand both high in DETECTED: go to IDLE anyway; counting restarts from the next cand cycle.
- Counter never exceeds CONFIRM_CYCLES.
- token_out_vec update each edge, first matching rule wins:
  - (|token_in_vec & ~token_clear) | origin | auto_pulse: token_out_vec <= proc_dep_vld_vec.
  - otherwise: token_out_vec <= 0.
- auto_pulse: single-cycle internal flag, registered one edge after DETECTED entry, only when AUTO_ORIGIN=1. It fires once per detection.

Decomposition:
- Shared package holds the FSM state enum (2-bit), the clog2 function, and the onehot(PROC_ID) constant helper.
- One sub-module, hls_dl_confirm_counter: inputs cand, clear and threshold; outputs reached. It implements the saturating consecutive-cycle counter.

Test Plan:
- Common setup: PROC_NUM=4, PROC_ID=1, IN=2, OUT=3, CONFIRM_CYCLES=4.
- Persistent self-dependence: in_chan_dep_vld_vec=2'b01, data ch0=4'b0010, proc_dep_vld_vec=3'b001, dl_detect_in=0, held 4 edges -> dl_detect_out=1 after 4th edge; dl_dep_snap=4'b0010; dl_chan_snap=2'b01; dl_snap_vld=1.
- Glitch filter: same stimulus held 3 edges, then dep bit cleared for 1 cycle, then restored -> dl_detect_out stays 0 until 4 further consecutive edges.
- Frozen dependence: dl_detect_in=1, token_in_vec=0, inputs changed to 4'b1000 -> dep_reg holds prior value; cand=0; no new detection.
- Clear vs cand collision: in DETECTED, assert token_clear with cand=1 -> next edge dl_detect_out=0, state IDLE; re-detect after 4 more cand edges; snapshot retained meanwhile.
- Token forwarding and auto origin: AUTO_ORIGIN=1, proc_dep_vld_vec=3'b101 -> token_out_vec=3'b101 for exactly 1 cycle, one edge after detection. token_in_vec=2'b10 with token_clear=1 -> token_out_vec=0.
- Async reset mid-CONFIRM (cnt=2): reset low between edges -> all outputs 0 immediately; out_chan_dep_data=4'b0010.
